// File: rtl/cam_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : cam_cmd_issuer
// Description : Host-side CAM initiator. Packs host commands into CAM beats,
//               collects search responses into a credit-protected FIFO.
//               Optional macro FIRST_MATCH_DECODE_EN selects first-match
//               response decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_cmd_issuer #(
    parameter int C_DATA_WIDTH     = 520,
    parameter int CAM_SIZE         = 128,
    parameter int INDEX_WIDTH      = $clog2(CAM_SIZE),
    parameter int ENTRIES_PER_BEAT = 16,
    parameter int KEY_WIDTH        = 32,
    parameter int RSP_DEPTH        = 8
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [3:0]                             cmd_op,
    input  logic [ENTRIES_PER_BEAT*KEY_WIDTH-1:0]  cmd_keys,
    output logic                                   m_tvalid,
    output logic [C_DATA_WIDTH-1:0]                m_tdata,
    input  logic                                   s_tvalid,
    input  logic [C_DATA_WIDTH-1:0]                s_tdata,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [3:0]                             rsp_op,
    output logic                                   rsp_hit,
    output logic [INDEX_WIDTH-1:0]                 rsp_index,
    output logic [INDEX_WIDTH:0]                   fill_count,
    output logic                                   err_badop,
    output logic                                   err_full,
    output logic                                   err_rsp_ovf,
    output logic                                   eos_done
);

    localparam int c_key_bits = ENTRIES_PER_BEAT * KEY_WIDTH;
    localparam int c_ptr_w    = $clog2(RSP_DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_fill_w   = INDEX_WIDTH + 1;
    localparam int c_ent_w    = 4 + 1 + INDEX_WIDTH;

    localparam logic [1:0] c_st_init  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [3:0] c_op_update_all = 4'h1;
    localparam logic [3:0] c_op_search_one = 4'h4;
    localparam logic [3:0] c_op_search_mq  = 4'h5;
    localparam logic [3:0] c_op_reset_all  = 4'h7;
    localparam logic [3:0] c_op_update_dup = 4'h8;
    localparam logic [3:0] c_op_eos        = 4'hF;

    localparam logic [c_fill_w-1:0] c_fill_step  = c_fill_w'(ENTRIES_PER_BEAT);
    localparam logic [c_fill_w-1:0] c_fill_limit = c_fill_w'(CAM_SIZE - ENTRIES_PER_BEAT);
    localparam logic [c_cnt_w-1:0]  c_depth      = c_cnt_w'(RSP_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one    = c_ptr_w'(1);

    logic [1:0]              r_state;
    logic [c_cnt_w-1:0]      r_credits;
    logic [c_fill_w-1:0]     r_fill;
    logic                    r_m_tvalid;
    logic [C_DATA_WIDTH-1:0] r_m_tdata;
    logic                    r_err_badop;
    logic                    r_err_full;
    logic                    r_err_ovf;
    logic                    r_eos_done;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic                    r_rsp_valid;
    logic [c_ent_w-1:0]      r_mem [RSP_DEPTH];

    logic                    w_is_update, w_is_search, w_is_reset, w_is_eos;
    logic                    w_needs_credit, w_accept, w_fwd, w_take_credit, w_fill_ok;
    logic                    w_pop, w_full, w_push, w_rsp_eos, w_hit;
    logic [INDEX_WIDTH-1:0]  w_index;
    logic [c_ent_w-1:0]      w_entry, w_head;
    logic [c_cnt_w-1:0]      w_count_nxt;
    logic [C_DATA_WIDTH-1:0] w_cmd_beat, w_init_beat;
    logic                    w_unused;

    assign w_is_update    = (cmd_op == c_op_update_all) || (cmd_op == c_op_update_dup);
    assign w_is_search    = (cmd_op == c_op_search_one) || (cmd_op == c_op_search_mq);
    assign w_is_reset     = (cmd_op == c_op_reset_all);
    assign w_is_eos       = (cmd_op == c_op_eos);
    assign w_needs_credit = w_is_search || w_is_eos;
    assign w_fill_ok      = (r_fill <= c_fill_limit);

    // Ready is a function of state, credits and opcode only, never of cmd_valid.
    assign cmd_ready     = (r_state == c_st_run) && (!w_needs_credit || (r_credits != '0));
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_fwd         = w_accept && (w_is_search || w_is_eos || w_is_reset ||
                                        (w_is_update && w_fill_ok));
    assign w_take_credit = w_accept && w_needs_credit;

    always_comb begin
        w_cmd_beat                          = '0;
        w_cmd_beat[C_DATA_WIDTH-2 -: 4]     = cmd_op;
        w_cmd_beat[c_key_bits-1:0]          = cmd_keys;
        w_init_beat                         = '0;
        w_init_beat[C_DATA_WIDTH-2 -: 4]    = c_op_reset_all;
    end

`ifdef FIRST_MATCH_DECODE_EN
    assign w_index = s_tdata[INDEX_WIDTH-1:0];
    assign w_hit   = (w_index != '0) || s_tdata[0];
`else
    assign w_index = '0;
    assign w_hit   = s_tdata[0];
`endif
    assign w_unused = &{1'b0, s_tdata[C_DATA_WIDTH-5:1]};

    assign w_rsp_eos   = (s_tdata[C_DATA_WIDTH-1 -: 4] == c_op_eos);
    assign w_entry     = {s_tdata[C_DATA_WIDTH-1 -: 4], w_hit, w_index};
    assign w_pop       = r_rsp_valid && rsp_ready;
    assign w_full      = (r_count == c_depth);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push      = s_tvalid && (!w_full || w_pop);
    assign w_count_nxt = r_count + (w_push ? c_cnt_one : '0) - (w_pop ? c_cnt_one : '0);
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= c_st_init;
            r_fill      <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_err_badop <= 1'b0;
            r_err_full  <= 1'b0;
            r_eos_done  <= 1'b0;
        end else begin
            r_m_tvalid  <= 1'b0;
            r_err_badop <= 1'b0;
            r_err_full  <= 1'b0;
            r_eos_done  <= 1'b0;
            case (r_state)
                c_st_init: begin
                    r_m_tvalid <= 1'b1;
                    r_m_tdata  <= w_init_beat;
                    r_fill     <= '0;
                    r_state    <= c_st_run;
                end
                c_st_run: begin
                    if (w_fwd) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= w_cmd_beat;
                    end
                    if (w_accept) begin
                        if (w_is_update) begin
                            if (w_fill_ok) r_fill <= r_fill + c_fill_step;
                            else           r_err_full <= 1'b1;
                        end else if (w_is_reset) begin
                            r_fill <= '0;
                        end else if (w_is_eos) begin
                            r_state <= c_st_drain;
                        end else if (!w_is_search) begin
                            r_err_badop <= 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_push && w_rsp_eos) begin
                        r_eos_done <= 1'b1;
                        r_state    <= c_st_run;
                    end
                end
                default: r_state <= c_st_init;
            endcase
        end
    end

    // Credits saturate so unsolicited responses cannot inflate them.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_credits <= c_depth;
        end else if (w_take_credit && !w_pop) begin
            r_credits <= r_credits - c_cnt_one;
        end else if (w_pop && !w_take_credit && (r_credits != c_depth)) begin
            r_credits <= r_credits + c_cnt_one;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count     <= w_count_nxt;
            r_rsp_valid <= (w_count_nxt != '0);
            if (s_tvalid && !w_push) r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_m_tdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_op      = w_head[c_ent_w-1 -: 4];
    assign rsp_hit     = w_head[INDEX_WIDTH];
    assign rsp_index   = w_head[INDEX_WIDTH-1:0];
    assign fill_count  = r_fill;
    assign err_badop   = r_err_badop;
    assign err_full    = r_err_full;
    assign err_rsp_ovf = r_err_ovf;
    assign eos_done    = r_eos_done;

endmodule
`default_nettype wire

// File: tb/tb_cam_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_cmd_issuer
// Description : Scoreboard testbench for cam_cmd_issuer with a CAM loopback
//               responder and a behavioural model (FIRST_MATCH_DECODE_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_cmd_issuer;

    localparam int W     = 520;
    localparam int CAM   = 128;
    localparam int IW    = 7;
    localparam int EPB   = 16;
    localparam int KB    = 16 * 32;
    localparam int DEPTH = 8;
    localparam int MD_INIT  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;

    logic          aclk, areset, cmd_valid, cmd_ready;
    logic [3:0]    cmd_op;
    logic [KB-1:0] cmd_keys;
    logic          m_tvalid;
    logic [W-1:0]  m_tdata;
    logic          s_tvalid;
    logic [W-1:0]  s_tdata;
    logic          rsp_valid, rsp_ready, rsp_hit;
    logic [3:0]    rsp_op;
    logic [IW-1:0] rsp_index;
    logic [IW:0]   fill_count;
    logic          err_badop, err_full, err_rsp_ovf, eos_done;

    cam_cmd_issuer dut (
        .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_keys(cmd_keys), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_hit(rsp_hit), .rsp_index(rsp_index), .fill_count(fill_count),
        .err_badop(err_badop), .err_full(err_full), .err_rsp_ovf(err_rsp_ovf), .eos_done(eos_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct { int when; logic [W-1:0] data; } beat_t;
    typedef struct { logic [3:0] op; logic hit; logic [IW-1:0] idx; } ent_t;

    beat_t        bq[$];
    ent_t         rq[$];
    logic [3:0]   cam_q[$];
    logic [W-1:0] inj_q[$];

    int  n_cmp = 0, n_fail = 0, cyc = 0;
    int  m_mode, m_fill, m_credits, at_full, at_bad, at_eos;
    bit  m_ovf, armed = 0, cam_en = 0, cam_hit1 = 0;
    int  rr_mode = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_beat(input logic [3:0] op, input logic [KB-1:0] k);
        return {1'b0, op, 3'b000, k};
    endfunction

    function automatic ent_t decode(input logic [W-1:0] d);
        ent_t e;
        e.op = d[W-1:W-4];
`ifdef FIRST_MATCH_DECODE_EN
        e.idx = d[IW-1:0];
        e.hit = (e.idx != 0) || d[0];
`else
        e.idx = '0;
        e.hit = d[0];
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    function automatic logic [KB-1:0] rand_keys();
        logic [KB-1:0] k;
        for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // Scoreboard/model: checks outputs produced by the last edge, then predicts the next edge.
    always @(negedge aclk) begin : mon
        int    mode_now;
        bit    exp_v, exp_rdy, need, pop, full, take;
        beat_t b;
        ent_t  e;
        if (armed) begin
            exp_v = (bq.size() > 0) && (bq[0].when == cyc);
            chk("m_tvalid", W'(m_tvalid), W'(exp_v));
            if (exp_v) begin
                chk("m_tdata", m_tdata, bq[0].data);
                void'(bq.pop_front());
            end
            chk("fill_count", W'(fill_count), W'(m_fill));
            chk("err_full", W'(err_full), W'(cyc == at_full));
            chk("err_badop", W'(err_badop), W'(cyc == at_bad));
            chk("eos_done", W'(eos_done), W'(cyc == at_eos));
            chk("err_rsp_ovf", W'(err_rsp_ovf), W'(m_ovf));
            chk("rsp_valid", W'(rsp_valid), W'(rq.size() > 0));
            if (rq.size() > 0) begin
                chk("rsp_op", W'(rsp_op), W'(rq[0].op));
                chk("rsp_hit", W'(rsp_hit), W'(rq[0].hit));
                chk("rsp_index", W'(rsp_index), W'(rq[0].idx));
            end
        end
        if (areset) begin
            bq.delete(); rq.delete();
            m_mode = MD_INIT; m_fill = 0; m_credits = DEPTH; m_ovf = 0;
            at_full = -1; at_bad = -1; at_eos = -1;
            armed = 1;
        end else if (armed) begin
            mode_now = m_mode;
            take     = 0;
            need     = (cmd_op == 4'h4) || (cmd_op == 4'h5) || (cmd_op == 4'hF);
            exp_rdy  = (mode_now == MD_RUN) && (!need || m_credits > 0);
            chk("cmd_ready", W'(cmd_ready), W'(exp_rdy));
            b.when = cyc + 1;
            if (mode_now == MD_INIT) begin
                b.data = mk_beat(4'h7, '0);
                bq.push_back(b);
                m_fill = 0;
                m_mode = MD_RUN;
            end else if (cmd_valid && exp_rdy) begin
                b.data = mk_beat(cmd_op, cmd_keys);
                case (cmd_op)
                    4'h1, 4'h8: begin
                        if (m_fill + EPB <= CAM) begin bq.push_back(b); m_fill += EPB; end
                        else at_full = cyc + 1;
                    end
                    4'h4, 4'h5: begin bq.push_back(b); take = 1; end
                    4'h7:       begin bq.push_back(b); m_fill = 0; end
                    4'hF:       begin bq.push_back(b); take = 1; m_mode = MD_DRAIN; end
                    default:    at_bad = cyc + 1;
                endcase
            end
            pop  = (rq.size() > 0) && rsp_ready;
            full = (rq.size() == DEPTH);
            if (pop) void'(rq.pop_front());
            if (s_tvalid) begin
                if (!full || pop) begin
                    e = decode(s_tdata);
                    rq.push_back(e);
                    if (mode_now == MD_DRAIN && e.op == 4'hF) begin
                        at_eos = cyc + 1;
                        m_mode = MD_RUN;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            if (take && !pop) m_credits--;
            else if (pop && !take && m_credits < DEPTH) m_credits++;
        end
    end

    // CAM loopback: remembers forwarded search/EOS opcodes and answers them later.
    always @(negedge aclk) begin
        if (areset) cam_q.delete();
        else if (m_tvalid && (m_tdata[W-2 -: 4] inside {4'h4, 4'h5, 4'hF}))
            cam_q.push_back(m_tdata[W-2 -: 4]);
    end

    initial begin
        logic [W-1:0] d;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        forever begin
            @(posedge aclk); #1;
            if (inj_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata  = inj_q.pop_front();
            end else if (cam_en && cam_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                d = rand_word();
                d[W-1:W-4] = cam_q.pop_front();
                if ($urandom_range(0, 3) == 0) d[IW-1:0] = '0;
                if (cam_hit1) d[0] = 1'b1;
                s_tvalid = 1'b1;
                s_tdata  = d;
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (rr_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [KB-1:0] keys);
        bit done = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_keys = keys;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge aclk);
            done = cmd_ready;
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_accept_timeout op=%0h: got no accept required accept", op);
        end
    endtask

    task automatic inject(input logic [3:0] op, input logic [IW-1:0] low);
        logic [W-1:0] d;
        d = rand_word();
        d[W-1:W-4] = op;
        d[IW-1:0]  = low;
        inj_q.push_back(d);
    endtask

    initial begin
        logic [3:0] bad_ops [10];
        int r;
        bad_ops = '{4'h0, 4'h2, 4'h3, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        areset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_keys = '0;
        idle(3); areset = 1'b0;
        idle(4);
        // Fill the CAM past capacity, then clear it.
        repeat (9) send_cmd(4'h1, rand_keys());
        idle(2);
        send_cmd(4'h7, rand_keys());
        idle(2);
        // Exhaust credits with responses held back.
        rr_mode = 0;
        repeat (8) send_cmd(4'h4, rand_keys());
        cmd_valid = 1'b1; cmd_op = 4'h4; cmd_keys = rand_keys();
        idle(5);
        cmd_valid = 1'b0;
        cam_hit1 = 1; cam_en = 1;
        idle(25);
        rr_mode = 1;
        repeat (2) send_cmd(4'h5, rand_keys());
        idle(20);
        send_cmd(4'h3, rand_keys());
        send_cmd(4'hB, rand_keys());
        idle(3);
        // End of stream with two searches outstanding.
        cam_en = 0; rr_mode = 0;
        repeat (2) send_cmd(4'h4, rand_keys());
        send_cmd(4'hF, rand_keys());
        cmd_valid = 1'b1; cmd_op = 4'h4;
        idle(5);
        cmd_valid = 1'b0;
        cam_en = 1;
        idle(20);
        rr_mode = 1;
        idle(10);
        // Overflow the response FIFO with unsolicited beats, then reset.
        cam_en = 0; rr_mode = 0; cam_hit1 = 0;
        inject(4'h4, 7'h2A);
        repeat (8) inject(4'h5, 7'($urandom_range(0, 127)));
        idle(15);
        rr_mode = 1;
        idle(3);
        rr_mode = 0;
        idle(3);
        areset = 1'b1; idle(2); areset = 1'b0;
        idle(5);
        // Randomized traffic.
        cam_en = 1; rr_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 6)        send_cmd(($urandom_range(0, 1) != 0) ? 4'h1 : 4'h8, rand_keys());
            else if (r < 12)  send_cmd(($urandom_range(0, 1) != 0) ? 4'h4 : 4'h5, rand_keys());
            else if (r == 12) send_cmd(4'h7, rand_keys());
            else if (r == 13) send_cmd(4'hF, rand_keys());
            else if (r < 16)  send_cmd(bad_ops[$urandom_range(0, 9)], rand_keys());
            else              idle($urandom_range(0, 2));
            if (i == 150) begin
                areset = 1'b1; idle(1); areset = 1'b0;
            end
        end
        rr_mode = 1;
        for (int t = 0; t < 3000 && (rq.size() > 0 || cam_q.size() > 0 || bq.size() > 0); t++) idle(1);
        if (rq.size() > 0 || cam_q.size() > 0 || bq.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", rq.size() + cam_q.size() + bq.size());
        end
        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
